// File: rtl/md_iter_unit_if.sv
// Request/response bundle between the core and the RV32M multi-cycle unit.
// The core drives the request (master); md_iter_unit answers (slave).
interface md_iter_unit_if #(
  parameter int unsigned WIDTH = 32
);
  logic             start;
  logic [2:0]       funct3;
  logic [WIDTH-1:0] op1;
  logic [WIDTH-1:0] op2;
  logic             flush;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] result;
  logic             zero;

  modport master (
    output start, funct3, op1, op2, flush,
    input  busy, done, result, zero
  );

  modport slave (
    input  start, funct3, op1, op2, flush,
    output busy, done, result, zero
  );
endinterface

// File: rtl/md_iter_unit.sv
// RV32M multiply/divide unit: single-cycle multiply, radix-2 restoring divide.
// busy stalls the core while dividing; done pulses once when result is valid.
module md_iter_unit #(
  parameter int unsigned WIDTH = 32
) (
  input  logic            clk,
  input  logic            rst_n,
  md_iter_unit_if.slave   bus
);

  localparam int unsigned CntW = $clog2(WIDTH + 1);

  typedef enum logic [1:0] {StIdle, StDivide, StDone} state_e;

  state_e             state_q, state_d;
  logic [WIDTH-1:0]   result_q, result_d;
  logic [WIDTH:0]     rem_q, rem_d;
  logic [WIDTH-1:0]   quo_q, quo_d;
  logic [WIDTH-1:0]   div_q, div_d;
  logic [CntW-1:0]    cnt_q, cnt_d;
  logic               qneg_q, qneg_d;
  logic               rneg_q, rneg_d;
  logic               is_rem_q, is_rem_d;

  logic               accept;
  logic               is_mul;
  logic               div_zero;
  logic               div_ovf;
  logic               short_op;
  logic               last_iter;
  logic               signed_div;
  logic               neg1, neg2;
  logic [WIDTH-1:0]   abs1, abs2;

  logic [WIDTH:0]     mul_a, mul_b;
  logic [2*WIDTH+1:0] prod;
  logic [WIDTH-1:0]   mul_res;

  logic [WIDTH:0]     rem_shift;
  logic [WIDTH-1:0]   quo_shift;
  logic [WIDTH:0]     trial;
  logic [WIDTH:0]     rem_next;
  logic [WIDTH-1:0]   quo_next;

  // Decode of the request and the cycle-0 operand preprocessing.
  always_comb begin
    accept     = bus.start && !bus.flush && (state_q == StIdle || state_q == StDone);
    is_mul     = !bus.funct3[2];
    signed_div = !bus.funct3[0];
    div_zero   = (bus.op2 == '0);
    div_ovf    = signed_div && (bus.op1 == {1'b1, {(WIDTH-1){1'b0}}}) && (bus.op2 == '1);
    short_op   = is_mul || div_zero || div_ovf;
    neg1       = signed_div && bus.op1[WIDTH-1];
    neg2       = signed_div && bus.op2[WIDTH-1];
    abs1       = neg1 ? (~bus.op1 + 1'b1) : bus.op1;
    abs2       = neg2 ? (~bus.op2 + 1'b1) : bus.op2;
    last_iter  = (cnt_q == CntW'(WIDTH - 1));
  end

  // Operands are sign- or zero-extended to WIDTH+1 bits, then to the full product width, so an
  // unsigned multiply of the extended values yields the correct two's-complement product.
  always_comb begin
    mul_a = {(bus.funct3 == 3'b001 || bus.funct3 == 3'b010) && bus.op1[WIDTH-1], bus.op1};
    mul_b = {(bus.funct3 == 3'b001) && bus.op2[WIDTH-1], bus.op2};
    prod  = {{(WIDTH+1){mul_a[WIDTH]}}, mul_a} * {{(WIDTH+1){mul_b[WIDTH]}}, mul_b};
    mul_res = (bus.funct3[1:0] == 2'b00) ? prod[WIDTH-1:0] : prod[2*WIDTH-1:WIDTH];
  end

  // One restoring step: shift {rem, quo} left, keep the difference when it does not borrow.
  always_comb begin
    rem_shift = {rem_q[WIDTH-1:0], quo_q[WIDTH-1]};
    quo_shift = {quo_q[WIDTH-2:0], 1'b0};
    trial     = rem_shift - {1'b0, div_q};
    rem_next  = trial[WIDTH] ? rem_shift : trial;
    quo_next  = {quo_shift[WIDTH-1:1], !trial[WIDTH]};
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      result_q <= '0;
      rem_q    <= '0;
      quo_q    <= '0;
      div_q    <= '0;
      cnt_q    <= '0;
      qneg_q   <= 1'b0;
      rneg_q   <= 1'b0;
      is_rem_q <= 1'b0;
    end else begin
      state_q  <= state_d;
      result_q <= result_d;
      rem_q    <= rem_d;
      quo_q    <= quo_d;
      div_q    <= div_d;
      cnt_q    <= cnt_d;
      qneg_q   <= qneg_d;
      rneg_q   <= rneg_d;
      is_rem_q <= is_rem_d;
    end
  end

  always_comb begin
    state_d = state_q;
    unique case (state_q)
      StIdle, StDone: begin
        if (accept) begin
          state_d = short_op ? StDone : StDivide;
        end else begin
          state_d = StIdle;
        end
      end
      StDivide: begin
        if (bus.flush) begin
          state_d = StIdle;
        end else if (last_iter) begin
          state_d = StDone;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  always_comb begin
    result_d = result_q;
    rem_d    = rem_q;
    quo_d    = quo_q;
    div_d    = div_q;
    cnt_d    = cnt_q;
    qneg_d   = qneg_q;
    rneg_d   = rneg_q;
    is_rem_d = is_rem_q;
    if (accept) begin
      if (is_mul) begin
        result_d = mul_res;
      end else if (div_zero) begin
        result_d = bus.funct3[1] ? bus.op1 : '1;
      end else if (div_ovf) begin
        result_d = bus.funct3[1] ? '0 : {1'b1, {(WIDTH-1){1'b0}}};
      end else begin
        rem_d    = '0;
        quo_d    = abs1;
        div_d    = abs2;
        cnt_d    = '0;
        qneg_d   = neg1 ^ neg2;
        rneg_d   = neg1;
        is_rem_d = bus.funct3[1];
      end
    end else if (state_q == StDivide && !bus.flush) begin
      rem_d = rem_next;
      quo_d = quo_next;
      cnt_d = cnt_q + 1'b1;
      if (last_iter) begin
        if (is_rem_q) begin
          result_d = rneg_q ? (~rem_next[WIDTH-1:0] + 1'b1) : rem_next[WIDTH-1:0];
        end else begin
          result_d = qneg_q ? (~quo_next + 1'b1) : quo_next;
        end
      end
    end
  end

  always_comb begin
    bus.busy   = (state_q == StDivide);
    bus.done   = (state_q == StDone);
    bus.result = result_q;
    bus.zero   = (result_q == '0);
  end

endmodule

// File: tb/tb_md_iter_unit.sv
// Directed bench for md_iter_unit: multiplies, divides, special cases, flush, ignored start,
// back-to-back issue and asynchronous reset, all against hand-computed results.
module tb_md_iter_unit;

  logic clk;
  logic rst_n;
  int   n_checks;
  int   n_fails;

  md_iter_unit_if #(.WIDTH(32)) bus ();

  md_iter_unit #(.WIDTH(32)) dut (
    .clk   (clk),
    .rst_n (rst_n),
    .bus   (bus.slave)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fails++;
      $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
    end
  endtask

  // Drive the request at a negedge; the following posedge is the cycle-0 edge.
  task automatic issue(input logic [2:0] f3, input logic [31:0] a, input logic [31:0] b);
    bus.start  = 1'b1;
    bus.funct3 = f3;
    bus.op1    = a;
    bus.op2    = b;
    @(posedge clk);
    #1 bus.start = 1'b0;
  endtask

  // Walk cycles 1.. until done; optionally pulse a stray MUL start in cycle poke_cyc.
  task automatic wait_done(input int poke_cyc, output int lat, output int busy_cnt);
    lat      = 0;
    busy_cnt = 0;
    for (int c = 1; c <= 40; c++) begin
      @(negedge clk);
      bus.start = 1'b0;
      if (bus.done) begin
        lat = c;
        break;
      end
      if (bus.busy) busy_cnt++;
      if (c == poke_cyc) begin
        bus.start  = 1'b1;
        bus.funct3 = 3'b000;
        bus.op1    = 32'd3;
        bus.op2    = 32'd3;
      end
    end
    if (lat == 0) check("done_timeout", 32'd0, 32'd1);
  endtask

  task automatic run_op(input string tag, input logic [2:0] f3, input logic [31:0] a,
                        input logic [31:0] b, input logic [31:0] exp, input int exp_lat);
    int lat;
    int bc;
    issue(f3, a, b);
    wait_done(0, lat, bc);
    check({tag, "_result"}, bus.result, exp);
    check({tag, "_zero"}, {31'd0, bus.zero}, {31'd0, exp == 32'd0});
    check({tag, "_latency"}, lat, exp_lat);
    check({tag, "_busy_cycles"}, bc, (exp_lat == 1) ? 0 : 32);
  endtask

  initial begin
    int lat;
    int bc;
    n_checks   = 0;
    n_fails    = 0;
    rst_n      = 1'b0;
    bus.start  = 1'b0;
    bus.flush  = 1'b0;
    bus.funct3 = 3'b000;
    bus.op1    = '0;
    bus.op2    = '0;
    @(negedge clk);
    check("rst_busy", {31'd0, bus.busy}, 32'd0);
    check("rst_done", {31'd0, bus.done}, 32'd0);
    check("rst_result", bus.result, 32'd0);
    check("rst_zero", {31'd0, bus.zero}, 32'd1);
    rst_n = 1'b1;
    @(negedge clk);

    // Consecutive calls also exercise issue in the done cycle.
    run_op("mul",    3'b000, 32'd7,        32'hFFFFFFFD, 32'hFFFFFFEB, 1);
    run_op("mulh",   3'b001, 32'h80000000, 32'h80000000, 32'h40000000, 1);
    run_op("mulhu",  3'b011, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 1);
    run_op("mulhsu", 3'b010, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFF, 1);
    run_op("div",    3'b100, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFD, 33);
    run_op("rem",    3'b110, 32'hFFFFFFF9, 32'd2,        32'hFFFFFFFF, 33);
    run_op("divu",   3'b101, 32'd100,      32'd7,        32'd14,       33);
    run_op("remu",   3'b111, 32'd100,      32'd7,        32'd2,        33);
    run_op("div0",   3'b100, 32'd5,        32'd0,        32'hFFFFFFFF, 1);
    run_op("remu0",  3'b111, 32'd5,        32'd0,        32'd5,        1);
    run_op("divovf", 3'b100, 32'h80000000, 32'hFFFFFFFF, 32'h80000000, 1);
    run_op("removf", 3'b110, 32'h80000000, 32'hFFFFFFFF, 32'd0,        1);
    run_op("mulb2b", 3'b000, 32'd6,        32'd7,        32'd42,       1);

    // Flush in cycle 10 of a divide.
    @(negedge clk);
    issue(3'b101, 32'd100, 32'd7);
    for (int c = 1; c < 10; c++) @(negedge clk);
    check("flush_busy_before", {31'd0, bus.busy}, 32'd1);
    bus.flush = 1'b1;
    @(posedge clk);
    #1 bus.flush = 1'b0;
    @(negedge clk);
    check("flush_busy", {31'd0, bus.busy}, 32'd0);
    check("flush_done", {31'd0, bus.done}, 32'd0);
    check("flush_result", bus.result, 32'd42);
    issue(3'b000, 32'd3, 32'd4);
    @(negedge clk);
    check("flush_mul_done", {31'd0, bus.done}, 32'd1);
    check("flush_mul_result", bus.result, 32'd12);

    // Stray start in cycle 5 of a divide must be ignored.
    @(negedge clk);
    issue(3'b100, 32'd100, 32'hFFFFFFF9);
    wait_done(5, lat, bc);
    check("ign_result", bus.result, 32'hFFFFFFF2);
    check("ign_latency", lat, 33);
    check("ign_busy_cycles", bc, 32);
    @(negedge clk);
    check("ign_done_pulse", {31'd0, bus.done}, 32'd0);

    // Asynchronous reset in cycle 20 of a divide.
    issue(3'b101, 32'd1000, 32'd3);
    for (int c = 1; c < 20; c++) @(negedge clk);
    #2 rst_n = 1'b0;
    #1;
    check("arst_busy", {31'd0, bus.busy}, 32'd0);
    check("arst_done", {31'd0, bus.done}, 32'd0);
    check("arst_result", bus.result, 32'd0);
    check("arst_zero", {31'd0, bus.zero}, 32'd1);
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    run_op("post_rst_div", 3'b100, 32'd10, 32'd3, 32'd3, 33);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
    $finish;
  end

endmodule
